fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000: first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; clears all state immediately.
REQ-004 imem_req  output  1  instruction-memory read request, held high until acknowledged.
REQ-005 imem_addr  output  32  word address of the outstanding request, stable while imem_req=1.
REQ-006 imem_ack  input  1  read data valid this cycle; sampled only while imem_req=1.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 pc_sel  input  1  redirect strobe from decode (taken branch/jump/jr).
REQ-009 npc  input  32  redirect target, valid when pc_sel=1.
REQ-010 shall  input  1  decode stall; head instruction is not consumed.
REQ-011 instr  output  32  head instruction word to decode; 32'h0 when empty.
REQ-012 pc  output  32  address of head instruction; 32'h0 when empty.
REQ-013 pc4  output  32  pc+4 of head instruction; 32'h0 when empty.
REQ-014 instr_valid  output  1  head entry present.

Function
REQ-015 Block SHALL hold a fetch PC register (pc_q), a 2-entry FIFO of {pc, instr}, and a 3-state FSM IDLE/WAIT/DROP.
REQ-016 Consume event SHALL be instr_valid=1 and shall=0 in the same cycle; it pops the FIFO head.
REQ-017 IDLE: if FIFO count<2 and pc_sel=0, latch imem_addr<=pc_q and go WAIT; otherwise stay IDLE.
REQ-018 WAIT: imem_req=1; on imem_ack=1 and pc_sel=0, push {imem_addr, imem_rdata}, pc_q<=pc_q+4 (mod 2^32), go IDLE.
REQ-019 imem_req SHALL be 0 in IDLE and 1 in WAIT and DROP.
REQ-020 Redirect (pc_sel=1) SHALL have priority over push and pop: pc_q<=npc, FIFO flushed, instr_valid=0 next cycle.
REQ-021 Redirect in IDLE: go IDLE, next request uses npc.
REQ-022 Redirect in WAIT with imem_ack=1: discard rdata, go IDLE; with imem_ack=0: go DROP.
REQ-023 DROP: imem_req stays 1 with unchanged imem_addr; on imem_ack discard rdata, go IDLE; further pc_sel in DROP updates pc_q, flushes, stays DROP unless ack the same cycle (then IDLE).
REQ-024 Push and pop in the same cycle SHALL keep count unchanged and preserve order.
REQ-025 FIFO SHALL never overflow: a request is issued only when count<2, and only one request is outstanding at a time.
REQ-026 Latency: ack in cycle N makes instruction visible on instr/pc/pc4 with instr_valid=1 in cycle N+1.
REQ-027 Outputs instr, pc, pc4, instr_valid SHALL be driven from registered FIFO state only, with no combinational path from imem_*.
REQ-028 While shall=1, instr, pc, pc4 SHALL be held unchanged unless pc_sel=1.

Reset
REQ-029 reset=0 SHALL asynchronously set pc_q=RESET_PC, FSM=IDLE, FIFO count=0, imem_addr=0, imem_req=0, instr/pc/pc4=0, instr_valid=0.
REQ-030 Reset asserted during WAIT/DROP SHALL abandon the request; any ack arriving after reset release without a request SHALL be ignored.
REQ-031 First request SHALL be issued in the first cycle after reset deasserts, with imem_addr=RESET_PC.

Structure
REQ-032 Shared package SHALL hold RESET_PC default, FSM state encoding (IDLE=0, WAIT=1, DROP=2), and NOP word 32'h0.
REQ-033 FIFO SHALL be a separate sub-module fetch_buf (depth 2, width 64, push/pop/flush/count).

Verification
REQ-034 Reset release, ack every cycle with rdata=addr^32'hFFFF_FFFF -> pc sequence 0x3000, 0x3004, 0x3008; pc4=pc+4.
REQ-035 shall=1 for 5 cycles with ack always ready -> at most 2 entries buffered, imem_req=0 once full, head pc held, no loss on release.
REQ-036 pc_sel=1, npc=0x3100 while WAIT with ack 3 cycles later -> that rdata dropped, next valid pc=0x3100.
REQ-037 pc_sel=1 in same cycle as ack and shall=0 -> no push, no pop effect, instr_valid=0 next cycle, next fetch 0x3100.
REQ-038 reset=0 mid-WAIT, async between clocks -> all outputs 0 immediately, refetch from 0x3000.
REQ-039 pc_q=32'hFFFF_FFFC fetch -> next address 32'h0000_0000 (wrap).

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants, state encoding and entry layout for the fetch stage
//
// Contents:
//   RESET_PC_DEFAULT : first fetch address after reset
//   NOP_WORD         : value presented on instr/pc/pc4 when the buffer is empty
//   BUF_WIDTH        : width of one buffered {pc, instr} entry
//   fetch_state_t    : request FSM encoding (IDLE=0, WAIT=1, DROP=2)
//   fetch_entry_t    : packed {pc, instr} buffer entry
//   next_pc()        : sequential successor address (wraps modulo 2^32)

package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam int          BUF_WIDTH        = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] next_pc(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory read channel between fetch and memory
//
// Signals:
//   imem_req   : read request, held until acknowledged
//   imem_addr  : word address of the outstanding request
//   imem_ack   : read data valid this cycle
//   imem_rdata : instruction word returned with imem_ack
// Modports:
//   master : fetch side (drives req/addr)
//   slave  : memory side (drives ack/rdata)

interface fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - two-entry in-order buffer of fetched {pc, instr} entries
//
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   i_push     : write i_wdata at the tail
//   i_pop      : retire the head entry
//   i_flush    : discard all entries (wins over push and pop)
//   i_wdata    : entry to write
//   o_rdata    : head entry, taken straight from storage registers
//   o_count    : number of valid entries (0..2)

module fetch_buf
   import fetch_stage_pkg::*;
#(
   parameter int WIDTH = BUF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_rd_ptr;
   logic             r_wr_ptr;
   logic [1:0]       r_count;

   logic             w_do_push;
   logic             w_do_pop;

   // A push into a full buffer is only accepted when the head leaves in
   // the same cycle; a pop of an empty buffer is ignored.
   assign w_do_pop  = i_pop && (r_count != 2'd0);
   assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_rd_ptr <= 1'b0;
         r_wr_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_do_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, memory request FSM and 2-deep buffer
//
// Ports:
//   clk         : clock
//   reset       : asynchronous active-low reset
//   imem        : instruction-memory channel (fetch_stage_if.master)
//   pc_sel, npc : redirect strobe and target from decode
//   shall       : decode stall, head entry is kept
//   instr       : head instruction word (NOP_WORD when empty)
//   pc, pc4     : head address and its successor (0 when empty)
//   instr_valid : head entry present

module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic               clk,
   input  logic               reset,
   fetch_stage_if.master      imem,
   input  logic               pc_sel,
   input  logic [31:0]        npc,
   input  logic               shall,
   output logic [31:0]        instr,
   output logic [31:0]        pc,
   output logic [31:0]        pc4,
   output logic               instr_valid
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_pc_q;
   logic [31:0]  w_pc_nxt;
   logic [31:0]  r_imem_addr;
   logic [31:0]  w_addr_nxt;

   logic         w_push;
   logic         w_pop;
   logic         w_flush;
   logic [1:0]   w_count;
   logic [63:0]  w_head;
   fetch_entry_t w_head_entry;
   fetch_entry_t w_wr_entry;
   logic         w_valid;
   logic         w_has_room;

   assign w_valid    = (w_count != 2'd0);
   assign w_has_room = (w_count != 2'd2);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_pc_q      <= RESET_PC;
         r_imem_addr <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc_q      <= w_pc_nxt;
         r_imem_addr <= w_addr_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and buffer control
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc_q;
      w_addr_nxt  = r_imem_addr;
      w_push      = 1'b0;
      // A redirect empties the buffer and suppresses the pop, whatever
      // state the request machine is in.
      w_flush     = pc_sel;
      w_pop       = w_valid && !shall && !pc_sel;

      case (r_state)
         ST_IDLE: begin
            if (pc_sel) begin
               w_pc_nxt = npc;
            end else if (w_has_room) begin
               // Only one request in flight and only with a free slot,
               // so the buffer can never overflow.
               w_addr_nxt  = r_pc_q;
               w_state_nxt = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (pc_sel) begin
               w_pc_nxt = npc;
               // Without an ack the memory still owes a word for the old
               // path; DROP swallows it while keeping the address stable.
               w_state_nxt = imem.imem_ack ? ST_IDLE : ST_DROP;
            end else if (imem.imem_ack) begin
               w_push      = 1'b1;
               w_pc_nxt    = next_pc(r_pc_q);
               w_state_nxt = ST_IDLE;
            end
         end

         ST_DROP: begin
            if (pc_sel) begin
               w_pc_nxt = npc;
            end
            if (imem.imem_ack) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Memory channel outputs
   // ------------------------------------------------------------------
   assign imem.imem_req  = (r_state != ST_IDLE);
   assign imem.imem_addr = r_imem_addr;

   // ------------------------------------------------------------------
   // Instruction buffer
   // ------------------------------------------------------------------
   assign w_wr_entry = '{pc: r_imem_addr, instr: imem.imem_rdata};

   fetch_buf #(
      .WIDTH (BUF_WIDTH)
   ) u_buf (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_wdata (w_wr_entry),
      .o_rdata (w_head),
      .o_count (w_count)
   );

   // Decode-facing outputs depend only on buffer registers, never on imem.
   assign w_head_entry = fetch_entry_t'(w_head);
   assign instr_valid  = w_valid;
   assign instr        = w_valid ? w_head_entry.instr           : NOP_WORD;
   assign pc           = w_valid ? w_head_entry.pc              : NOP_WORD;
   assign pc4          = w_valid ? next_pc(w_head_entry.pc)     : NOP_WORD;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_sel;
   logic [31:0] npc;
   logic        shall;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        instr_valid;

   fetch_stage_if mif ();

   fetch_stage #(
      .RESET_PC (32'h0000_3000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .imem        (mif),
      .pc_sel      (pc_sel),
      .npc         (npc),
      .shall       (shall),
      .instr       (instr),
      .pc          (pc),
      .pc4         (pc4),
      .instr_valid (instr_valid)
   );

   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [63:0] sb[$];
   logic [31:0] exp_pc;
   logic [31:0] drop_addr;
   bit          drop_pending;
   int          wait_cnt;
   int          ack_lat;
   bit          ack_rand;
   bit          spur_en;
   int          n_cons;
   bit          saw_wrap;
   bit          last_req;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      exp_pc       = 32'h0000_3000;
      drop_pending = 1'b0;
      drop_addr    = 32'h0;
      wait_cnt     = 0;
   endtask

   task automatic check_and_update(input bit req, input bit ack);
      bit          v_exp;
      logic [63:0] head;
      v_exp = (sb.size() != 0);
      head  = v_exp ? sb[0] : 64'h0;
      chk("valid", {31'b0, instr_valid}, {31'b0, v_exp});
      if (v_exp) begin
         chk("pc", pc, head[63:32]);
         chk("instr", instr, head[31:0]);
         chk("pc4", pc4, head[63:32] + 32'd4);
      end else begin
         chk("pc_empty", pc, 32'h0);
         chk("instr_empty", instr, 32'h0);
         chk("pc4_empty", pc4, 32'h0);
      end
      if (sb.size() == 2) chk("req_full", {31'b0, mif.imem_req}, 32'h0);
      if (req) chk("addr", mif.imem_addr, drop_pending ? drop_addr : exp_pc);

      if (pc_sel) begin
         sb.delete();
         if (req && !ack) begin
            if (!drop_pending) drop_addr = exp_pc;
            drop_pending = 1'b1;
         end else if (req && ack) begin
            drop_pending = 1'b0;
         end
         exp_pc = npc;
      end else begin
         if (v_exp && !shall) begin
            void'(sb.pop_front());
            n_cons++;
            if (head[63:32] == 32'h0) saw_wrap = 1'b1;
         end
         if (req && ack) begin
            if (drop_pending) begin
               drop_pending = 1'b0;
            end else begin
               sb.push_back({exp_pc, exp_pc ^ 32'hFFFF_FFFF});
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
      if (req && !ack) wait_cnt++;
      else wait_cnt = 0;
   endtask

   // sel_mode: 0 none, 1 always, 2 only while waiting without ack,
   // 3 only with an ack, 4 random
   task automatic step(input int sel_mode, input logic [31:0] tgt, input logic stl, output bit fired);
      bit req_now;
      bit ack_now;
      @(posedge clk);
      #1;
      req_now = mif.imem_req;
      if (req_now) ack_now = ack_rand ? ($urandom_range(0, 2) != 0) : (wait_cnt >= ack_lat);
      else         ack_now = spur_en && ($urandom_range(0, 3) == 0);
      case (sel_mode)
         1:       fired = 1'b1;
         2:       fired = req_now && !ack_now;
         3:       fired = req_now && ack_now;
         4:       fired = ($urandom_range(0, 15) == 0);
         default: fired = 1'b0;
      endcase
      pc_sel         = fired;
      npc            = tgt;
      shall          = stl;
      mif.imem_ack   = ack_now;
      mif.imem_rdata = req_now ? (mif.imem_addr ^ 32'hFFFF_FFFF) : $urandom();
      last_req       = req_now;
      @(negedge clk);
      check_and_update(req_now, ack_now);
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_req"},   {31'b0, mif.imem_req}, 32'h0);
      chk({tag, "_addr"},  mif.imem_addr, 32'h0);
      chk({tag, "_valid"}, {31'b0, instr_valid}, 32'h0);
      chk({tag, "_instr"}, instr, 32'h0);
      chk({tag, "_pc"},    pc, 32'h0);
      chk({tag, "_pc4"},   pc4, 32'h0);
   endtask

   initial begin
      bit f;
      int c0;
      int tries;
      reset          = 1'b0;
      pc_sel         = 1'b0;
      npc            = 32'h0;
      shall          = 1'b0;
      mif.imem_ack   = 1'b0;
      mif.imem_rdata = 32'h0;
      ack_lat  = 0;
      ack_rand = 1'b0;
      spur_en  = 1'b0;
      n_cons   = 0;
      saw_wrap = 1'b0;
      last_req = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("rst");
      #2 reset = 1'b1;
      model_reset();

      // Back-to-back acks: 0x3000, 0x3004, 0x3008, ...
      step(0, 32'h0, 1'b0, f);
      chk("first_req", {31'b0, last_req}, 32'h1);
      repeat (19) step(0, 32'h0, 1'b0, f);
      chk("progress_seq", {31'b0, n_cons >= 8}, 32'h1);

      // Stall with memory always ready: buffer fills, request stops
      repeat (5) step(0, 32'h0, 1'b1, f);
      c0 = n_cons;
      repeat (10) step(0, 32'h0, 1'b0, f);
      chk("progress_stall", {31'b0, (n_cons - c0) >= 4}, 32'h1);

      // Redirect while waiting, ack arrives 3 cycles later and is dropped
      ack_lat = 3;
      f = 1'b0;
      tries = 0;
      while (!f && tries < 10) begin
         step(2, 32'h0000_3100, 1'b0, f);
         tries++;
      end
      chk("redir_wait_fired", {31'b0, f}, 32'h1);
      c0 = n_cons;
      repeat (16) step(0, 32'h0, 1'b0, f);
      chk("progress_drop", {31'b0, (n_cons - c0) >= 1}, 32'h1);

      // Redirect in the same cycle as an ack
      ack_lat = 0;
      f = 1'b0;
      tries = 0;
      while (!f && tries < 10) begin
         step(3, 32'h0000_3100, 1'b0, f);
         tries++;
      end
      chk("redir_ack_fired", {31'b0, f}, 32'h1);
      c0 = n_cons;
      repeat (10) step(0, 32'h0, 1'b0, f);
      chk("progress_redir_ack", {31'b0, (n_cons - c0) >= 3}, 32'h1);

      // Address wrap past 0xFFFF_FFFC
      step(1, 32'hFFFF_FFF8, 1'b0, f);
      repeat (14) step(0, 32'h0, 1'b0, f);
      chk("wrap", {31'b0, saw_wrap}, 32'h1);

      // Random stalls, redirects, ack gaps and spurious acks
      ack_rand = 1'b1;
      spur_en  = 1'b1;
      c0 = n_cons;
      for (int i = 0; i < 400; i++) begin
         step(4, 32'h0000_4000 + ({22'h0, 8'($urandom_range(0, 255))} << 2),
              ($urandom_range(0, 3) == 0), f);
      end
      chk("progress_rand", {31'b0, (n_cons - c0) >= 30}, 32'h1);

      // Asynchronous reset in the middle of a wait
      ack_rand = 1'b0;
      spur_en  = 1'b0;
      ack_lat  = 5;
      tries = 0;
      step(0, 32'h0, 1'b0, f);
      while (!last_req && tries < 10) begin
         step(0, 32'h0, 1'b0, f);
         tries++;
      end
      chk("wait_before_rst", {31'b0, last_req}, 32'h1);
      #2 reset = 1'b0;
      #1 check_zero_outputs("async_rst");
      mif.imem_ack   = 1'b1;
      mif.imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      @(negedge clk);
      check_zero_outputs("rst_hold");
      #2 reset = 1'b1;
      model_reset();
      ack_lat = 0;
      step(0, 32'h0, 1'b0, f);
      chk("refetch_req", {31'b0, last_req}, 32'h1);
      c0 = n_cons;
      repeat (12) step(0, 32'h0, 1'b0, f);
      chk("progress_refetch", {31'b0, (n_cons - c0) >= 4}, 32'h1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
